// File: rtl/trace_buffer_pkg.sv
// Shared constants, defines and types for the retirement trace buffer and its classifier.
// Optional TRACE_DISPLAY_EN (see trace_buffer.sv) prints every buffer write.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef TRACE_CLASS_WIDTH
`define TRACE_CLASS_WIDTH 3
`define TRACE_CLASS_UNKNOWN 3'd0
`define TRACE_CLASS_R 3'd1
`define TRACE_CLASS_ADDI 3'd2
`define TRACE_CLASS_LW 3'd3
`define TRACE_CLASS_SW 3'd4
`define TRACE_CLASS_BRANCH 3'd5
`define TRACE_CLASS_JAL 3'd6
`define TRACE_ST_IDLE 2'd0
`define TRACE_ST_CAPTURE 2'd1
`define TRACE_ST_POST 2'd2
`define TRACE_ST_DRAIN 2'd3
`endif
`ifndef OPC_OP
`define OPC_OP 7'b0110011
`define OPC_OP_IMM 7'b0010011
`define OPC_LOAD 7'b0000011
`define OPC_STORE 7'b0100011
`define OPC_BRANCH 7'b1100011
`define OPC_JAL 7'b1101111
`define F3_ADD_SUB 3'b000
`define F3_SLL 3'b001
`define F3_XOR 3'b100
`define F3_SRL 3'b101
`define F3_OR 3'b110
`define F3_AND 3'b111
`define F3_WORD 3'b010
`define F3_BEQ 3'b000
`define F3_BLT 3'b100
`define F7_BASE 7'b0000000
`define F7_ALT 7'b0100000
`endif

package trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = `TRACE_ST_IDLE,
    ST_CAPTURE = `TRACE_ST_CAPTURE,
    ST_POST    = `TRACE_ST_POST,
    ST_DRAIN   = `TRACE_ST_DRAIN
  } trace_state_e;

  typedef enum logic [`TRACE_CLASS_WIDTH-1:0] {
    CLASS_UNKNOWN = `TRACE_CLASS_UNKNOWN,
    CLASS_R       = `TRACE_CLASS_R,
    CLASS_ADDI    = `TRACE_CLASS_ADDI,
    CLASS_LW      = `TRACE_CLASS_LW,
    CLASS_SW      = `TRACE_CLASS_SW,
    CLASS_BRANCH  = `TRACE_CLASS_BRANCH,
    CLASS_JAL     = `TRACE_CLASS_JAL
  } trace_class_e;

endpackage

// File: rtl/trace_classify.sv
// Combinational instruction classifier: maps a retired RV32 word onto a trace class.
// Anything outside the supported subset is reported as UNKNOWN.
module trace_classify
  import trace_buffer_pkg::*;
(
  input  logic [`INST_WIDTH-1:0]        inst,
  output logic [`TRACE_CLASS_WIDTH-1:0] inst_class
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // Register and immediate fields do not affect the class.
  assign unused_fields = ^{inst[24:15], inst[11:7]};

  always_comb begin
    inst_class = CLASS_UNKNOWN;
    case (opcode)
      `OPC_OP: begin
        if (funct7 == `F7_BASE) begin
          case (funct3)
            `F3_ADD_SUB, `F3_SLL, `F3_XOR, `F3_SRL, `F3_OR, `F3_AND: inst_class = CLASS_R;
            default: inst_class = CLASS_UNKNOWN;
          endcase
        end else if (funct7 == `F7_ALT && funct3 == `F3_ADD_SUB) begin
          inst_class = CLASS_R;
        end
      end
      `OPC_OP_IMM: if (funct3 == `F3_ADD_SUB) inst_class = CLASS_ADDI;
      `OPC_LOAD:   if (funct3 == `F3_WORD) inst_class = CLASS_LW;
      `OPC_STORE:  if (funct3 == `F3_WORD) inst_class = CLASS_SW;
      `OPC_BRANCH: if (funct3 == `F3_BEQ || funct3 == `F3_BLT) inst_class = CLASS_BRANCH;
      `OPC_JAL:    inst_class = CLASS_JAL;
      default:     inst_class = CLASS_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/trace_buffer.sv
// Retirement trace capture: circular buffer with PC/UNKNOWN trigger, post-trigger fill and drain.
// Define TRACE_DISPLAY_EN to print a disassembly line for every buffer write.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ret_valid,
  input  logic [PC_WIDTH-1:0]           ret_pc,
  input  logic [`INST_WIDTH-1:0]        ret_inst,
  input  logic [`REG_DATA_WIDTH-1:0]    ret_imm,
  input  logic                          arm,
  input  logic                          trig_en,
  input  logic [PC_WIDTH-1:0]           trig_pc,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [PC_WIDTH-1:0]           rd_pc,
  output logic [`INST_WIDTH-1:0]        rd_inst,
  output logic [`REG_DATA_WIDTH-1:0]    rd_imm,
  output logic [`TRACE_CLASS_WIDTH-1:0] rd_class,
  output logic [1:0]                    state,
  output logic                          triggered,
  output logic [$clog2(DEPTH):0]        entry_cnt,
  output logic [CNT_WIDTH-1:0]          ret_cnt,
  output logic [CNT_WIDTH-1:0]          unk_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ECNT_W = PTR_W + 1;
  localparam logic [ECNT_W-1:0] FULL_CNT = ECNT_W'(DEPTH);

  logic [PC_WIDTH-1:0]           pc_mem    [DEPTH];
  logic [`INST_WIDTH-1:0]        inst_mem  [DEPTH];
  logic [`REG_DATA_WIDTH-1:0]    imm_mem   [DEPTH];
  logic [`TRACE_CLASS_WIDTH-1:0] class_mem [DEPTH];

  trace_state_e          state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ECNT_W-1:0]     entry_cnt_q, entry_cnt_d;
  logic [ECNT_W-1:0]     post_cnt_q, post_cnt_d;
  logic                  triggered_q, triggered_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;
  logic [CNT_WIDTH-1:0]  unk_cnt_q, unk_cnt_d;

  logic [`TRACE_CLASS_WIDTH-1:0] ret_class;
  logic                          do_clear;
  logic                          wr_en;
  logic                          trig_fire;

  trace_classify u_classify (
    .inst       (ret_inst),
    .inst_class (ret_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      entry_cnt_q <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      ret_cnt_q   <= '0;
      unk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      entry_cnt_q <= entry_cnt_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      ret_cnt_q   <= ret_cnt_d;
      unk_cnt_q   <= unk_cnt_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= ret_pc;
      inst_mem[wr_ptr_q]  <= ret_inst;
      imm_mem[wr_ptr_q]   <= ret_imm;
      class_mem[wr_ptr_q] <= ret_class;
    end
  end

  // Arm wins over a same-cycle retirement, so that retirement is never recorded.
  always_comb begin
    do_clear  = arm && (state_q != ST_DRAIN);
    wr_en     = ret_valid && !do_clear && (state_q == ST_CAPTURE || state_q == ST_POST);
    trig_fire = wr_en && (state_q == ST_CAPTURE) &&
                ((trig_en && ret_pc == trig_pc) || ret_class == CLASS_UNKNOWN);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    entry_cnt_d = entry_cnt_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    rd_valid_d  = rd_valid_q;
    ret_cnt_d   = ret_cnt_q;
    unk_cnt_d   = unk_cnt_q;

    if (do_clear) begin
      state_d     = ST_CAPTURE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      entry_cnt_d = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      ret_cnt_d   = '0;
      unk_cnt_d   = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (entry_cnt_q != FULL_CNT) entry_cnt_d = entry_cnt_q + 1'b1;
      if (ret_cnt_q != {CNT_WIDTH{1'b1}}) ret_cnt_d = ret_cnt_q + 1'b1;
      if (ret_class == CLASS_UNKNOWN && unk_cnt_q != {CNT_WIDTH{1'b1}})
        unk_cnt_d = unk_cnt_q + 1'b1;
      if (state_q == ST_CAPTURE) begin
        if (trig_fire) begin
          triggered_d = 1'b1;
          if (POST_TRIG == 0) begin
            state_d = ST_DRAIN;
          end else begin
            post_cnt_d = ECNT_W'(POST_TRIG);
            state_d    = ST_POST;
          end
        end
      end else begin
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == ECNT_W'(1)) state_d = ST_DRAIN;
      end
      // Only meaningful on the write that enters DRAIN: points at the oldest entry.
      rd_ptr_d = wr_ptr_d - entry_cnt_d[PTR_W-1:0];
    end else if (state_q == ST_DRAIN) begin
      if (!rd_valid_q) begin
        if (entry_cnt_q == '0) state_d = ST_IDLE;
        else                   rd_valid_d = 1'b1;
      end else if (rd_ready) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        entry_cnt_d = entry_cnt_q - 1'b1;
        if (entry_cnt_q == ECNT_W'(1)) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_pc     = pc_mem[rd_ptr_q];
  assign rd_inst   = inst_mem[rd_ptr_q];
  assign rd_imm    = imm_mem[rd_ptr_q];
  assign rd_class  = class_mem[rd_ptr_q];
  assign state     = state_q;
  assign triggered = triggered_q;
  assign entry_cnt = entry_cnt_q;
  assign ret_cnt   = ret_cnt_q;
  assign unk_cnt   = unk_cnt_q;

`ifdef TRACE_DISPLAY_EN
  string trace_tag;

  function automatic string r_mnemonic(input logic [2:0] f3, input logic alt);
    case (f3)
      `F3_ADD_SUB: return alt ? "sub" : "add";
      `F3_SLL:     return "sll";
      `F3_XOR:     return "xor";
      `F3_SRL:     return "srl";
      `F3_OR:      return "or";
      default:     return "and";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && wr_en) begin
      trace_tag = trig_fire ? " TRIG" : "";
      case (ret_class)
        CLASS_R:
          $display("%s x%0d, x%0d, x%0d%s", r_mnemonic(ret_inst[14:12], ret_inst[30]),
                   ret_inst[11:7], ret_inst[19:15], ret_inst[24:20], trace_tag);
        CLASS_ADDI:
          $display("addi x%0d, x%0d, %0d%s", ret_inst[11:7], ret_inst[19:15],
                   $signed(ret_imm), trace_tag);
        CLASS_LW:
          $display("lw x%0d, %0d(x%0d)%s", ret_inst[11:7], $signed(ret_imm),
                   ret_inst[19:15], trace_tag);
        CLASS_SW:
          $display("sw x%0d, %0d(x%0d)%s", ret_inst[24:20], $signed(ret_imm),
                   ret_inst[19:15], trace_tag);
        CLASS_BRANCH:
          $display("%s x%0d, x%0d, %0d%s", (ret_inst[14:12] == `F3_BEQ) ? "beq" : "blt",
                   ret_inst[19:15], ret_inst[24:20], $signed(ret_imm), trace_tag);
        CLASS_JAL:
          $display("jal x%0d, %0d%s", ret_inst[11:7], $signed(ret_imm), trace_tag);
        default:
          $display("unknown 0x%h%s", ret_inst, trace_tag);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=16); a second POST_TRIG=0 instance
// covers the immediate-drain case.
`timescale 1ns/1ps
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
module tb_trace_buffer;

  localparam logic [31:0] ADDI = 32'h0010_0093;  // addi x1, x0, 1
  localparam logic [31:0] BEQ  = 32'h0000_0063;  // beq x0, x0, 0
  localparam logic [31:0] UNK  = 32'hFFFF_FFFF;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;  // pc that never appears in a drain

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [31:0] ret_inst = '0;
  logic [31:0] ret_imm = '0;
  logic        arm = 1'b0;
  logic        arm0 = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        rd_ready = 1'b0;

  logic        rd_valid, triggered;
  logic [31:0] rd_pc, rd_inst, rd_imm;
  logic [2:0]  rd_class;
  logic [1:0]  state;
  logic [4:0]  entry_cnt;
  logic [15:0] ret_cnt, unk_cnt;

  logic        rd_valid0, triggered0;
  logic [31:0] rd_pc0, rd_inst0, rd_imm0;
  logic [2:0]  rd_class0;
  logic [1:0]  state0;
  logic [4:0]  entry_cnt0;
  logic [15:0] ret_cnt0, unk_cnt0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trace_buffer #(.DEPTH(16), .POST_TRIG(4), .PC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_imm(ret_imm), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_imm(rd_imm),
    .rd_class(rd_class), .state(state), .triggered(triggered), .entry_cnt(entry_cnt),
    .ret_cnt(ret_cnt), .unk_cnt(unk_cnt)
  );

  trace_buffer #(.DEPTH(16), .POST_TRIG(0), .PC_WIDTH(32), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_imm(ret_imm), .arm(arm0), .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_inst(rd_inst0), .rd_imm(rd_imm0),
    .rd_class(rd_class0), .state(state0), .triggered(triggered0), .entry_cnt(entry_cnt0),
    .ret_cnt(ret_cnt0), .unk_cnt(unk_cnt0)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // The immediate equals the pc so every drained entry carries a distinct imm too.
  task automatic retire(input logic [31:0] pc, input logic [31:0] inst);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = inst;
    ret_imm   = pc;
    step();
    ret_valid = 1'b0;
    $display("retire pc=0x%08h inst=0x%08h state=%0d entries=%0d", pc, inst, state, entry_cnt);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !rd_valid; i++) step();
    check_eq(tag, rd_valid, 1);
  endtask

  task automatic drain_expect(input string tag, input logic [31:0] first_pc, input int n,
                              input logic [31:0] unk_pc);
    logic [31:0] pc;
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc = first_pc + 32'(4 * i);
      wait_valid({tag, "_valid"});
      $display("drain %s pc=0x%08h class=%0d imm=0x%0h", tag, rd_pc, rd_class, rd_imm);
      check_eq({tag, "_pc"}, rd_pc, pc);
      check_eq({tag, "_class"}, rd_class, (pc == unk_pc) ? 3'd0 : 3'd2);
      check_eq({tag, "_imm"}, rd_imm, pc);
      step();
    end
    rd_ready = 1'b0;
    check_eq({tag, "_idle"}, state, 0);
    check_eq({tag, "_vdrop"}, rd_valid, 0);
    check_eq({tag, "_empty"}, entry_cnt, 0);
  endtask

  initial begin
    int idx;
    logic hs;

    #12;
    check_eq("rst_state", state, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_entries", entry_cnt, 0);
    check_eq("rst_trig", triggered, 0);
    check_eq("rst_retcnt", ret_cnt, 0);
    check_eq("rst_unkcnt", unk_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // PC-match trigger at 0x20, four post entries, 13 total.
    trig_en = 1'b1;
    trig_pc = 32'h20;
    pulse_arm();
    check_eq("t1_capture", state, 1);
    for (int i = 0; i < 13; i++) begin
      retire(32'(4 * i), ADDI);
      if (i == 8) check_eq("t1_post", state, 2);
    end
    check_eq("t1_drain", state, 3);
    check_eq("t1_entries", entry_cnt, 13);
    check_eq("t1_retcnt", ret_cnt, 13);
    check_eq("t1_unkcnt", unk_cnt, 0);
    check_eq("t1_trig", triggered, 1);
    check_eq("t1_first_gap", rd_valid, 0);
    drain_expect("t1", 32'h0, 13, NONE);

    // Wrap-around with UNKNOWN trigger: 25 writes, the newest 16 survive.
    trig_en = 1'b0;
    pulse_arm();
    check_eq("t2_trig_clr", triggered, 0);
    for (int i = 0; i < 20; i++) retire(32'(4 * i), ADDI);
    check_eq("t2_capture", state, 1);
    check_eq("t2_full", entry_cnt, 16);
    retire(32'h50, UNK);
    check_eq("t2_trig", triggered, 1);
    check_eq("t2_unkcnt", unk_cnt, 1);
    check_eq("t2_post", state, 2);
    for (int i = 1; i <= 4; i++) retire(32'h50 + 32'(4 * i), ADDI);
    check_eq("t2_drain", state, 3);
    check_eq("t2_entries", entry_cnt, 16);
    check_eq("t2_retcnt", ret_cnt, 25);
    drain_expect("t2", 32'h24, 16, 32'h50);

    // Backpressure: stall then alternate rd_ready.
    trig_en = 1'b1;
    trig_pc = 32'h8;
    pulse_arm();
    for (int i = 0; i < 7; i++) retire(32'(4 * i), ADDI);
    check_eq("t3_drain", state, 3);
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_stall_pc", rd_pc, 0);
      check_eq("t3_stall_cnt", entry_cnt, 7);
      step();
    end
    idx = 0;
    for (int c = 0; c < 40 && idx < 7; c++) begin
      rd_ready = (c % 2 == 0);
      check_eq("t3_pc", rd_pc, 32'(4 * idx));
      check_eq("t3_cnt", entry_cnt, 5'(7 - idx));
      check_eq("t3_valid_hold", rd_valid, 1);
      hs = rd_valid && rd_ready;
      step();
      if (hs) idx++;
    end
    rd_ready = 1'b0;
    check_eq("t3_count", idx, 7);
    check_eq("t3_idle", state, 0);

    // Arm with same-cycle retirement, then re-arm mid-POST.
    trig_pc = 32'h104;
    arm = 1'b1;
    ret_valid = 1'b1;
    ret_pc = 32'h100;
    ret_inst = ADDI;
    ret_imm = 32'h100;
    step();
    arm = 1'b0;
    ret_valid = 1'b0;
    check_eq("t4_capture", state, 1);
    check_eq("t4_nocap", entry_cnt, 0);
    check_eq("t4_retcnt", ret_cnt, 0);
    retire(32'h104, ADDI);
    check_eq("t4_post", state, 2);
    check_eq("t4_trig", triggered, 1);
    retire(32'h108, ADDI);
    check_eq("t4_entries", entry_cnt, 2);
    pulse_arm();
    check_eq("t4_rearm_state", state, 1);
    check_eq("t4_rearm_cnt", entry_cnt, 0);
    check_eq("t4_rearm_trig", triggered, 0);
    check_eq("t4_rearm_ret", ret_cnt, 0);

    // Asynchronous reset in the middle of a drain, then a clean run.
    trig_pc = 32'h200;
    for (int i = 0; i < 5; i++) retire(32'h200 + 32'(4 * i), ADDI);
    check_eq("t6_drain", state, 3);
    rd_ready = 1'b1;
    wait_valid("t6_valid");
    step();
    rd_ready = 1'b0;
    check_eq("t6_one_taken", entry_cnt, 4);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_state", state, 0);
    check_eq("t6_rst_valid", rd_valid, 0);
    check_eq("t6_rst_cnt", entry_cnt, 0);
    check_eq("t6_rst_trig", triggered, 0);
    check_eq("t6_rst_ret", ret_cnt, 0);
    #1;
    rst_n = 1'b1;
    step();
    trig_pc = 32'h40;
    pulse_arm();
    for (int i = 0; i < 5; i++) retire(32'h40 + 32'(4 * i), ADDI);
    check_eq("t6_rerun_drain", state, 3);
    drain_expect("t6", 32'h40, 5, NONE);

    // POST_TRIG=0 instance: trigger on the first retirement drains a single beq.
    trig_pc = 32'h0;
    arm0 = 1'b1;
    step();
    arm0 = 1'b0;
    check_eq("t5_capture", state0, 1);
    retire(32'h0, BEQ);
    check_eq("t5_drain", state0, 3);
    check_eq("t5_entries", entry_cnt0, 1);
    check_eq("t5_trig", triggered0, 1);
    check_eq("t5_main_idle", entry_cnt, 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && !rd_valid0; i++) step();
    check_eq("t5_valid", rd_valid0, 1);
    $display("drain t5 pc=0x%08h class=%0d inst=0x%08h", rd_pc0, rd_class0, rd_inst0);
    check_eq("t5_pc", rd_pc0, 0);
    check_eq("t5_class", rd_class0, 5);
    check_eq("t5_inst", rd_inst0, BEQ);
    step();
    rd_ready = 1'b0;
    check_eq("t5_idle", state0, 0);
    check_eq("t5_empty", entry_cnt0, 0);
    check_eq("t5_vdrop", rd_valid0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
